// File: rtl/rv_dp_md.sv
// rv_dp_md: multicycle RISC-V datapath with an integrated radix-2
// multiply/divide unit (MUL, MULHU, DIVU, REMU).
// The MD unit is a three-state FSM (IDLE, RUN, DONE). It takes one shift
// step per cycle for DPWIDTH cycles and then pulses md_done for one cycle.
// Handshake: md_start is sampled only in IDLE or DONE. md_busy is high
// exactly while iterating. md_done is a one-cycle pulse, and md_res is
// valid from that cycle until the next md_done.
module rv_dp_md #(
    parameter int DPWIDTH = 32,
    parameter int RFSIZE  = 32,
    localparam int CNTW   = $clog2(DPWIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [DPWIDTH-1:0] imem_addr,
    input  logic [DPWIDTH-1:0] imem_datain,
    output logic [DPWIDTH-1:0] dmem_addr,
    output logic [DPWIDTH-1:0] dmem_dataout,
    input  logic [DPWIDTH-1:0] dmem_datain,
    output logic [DPWIDTH-1:0] instr,
    output logic               zero,
    input  logic               pcsource,
    input  logic               pcwrite,
    input  logic               pccen,
    input  logic               irwrite,
    input  logic               mdrwrite,
    input  logic               regwen,
    input  logic [1:0]         wbsel,
    input  logic [2:0]         immsel,
    input  logic               asel,
    input  logic               bsel,
    input  logic [3:0]         alusel,
    input  logic               md_start,
    input  logic [1:0]         md_op,
    output logic               md_busy,
    output logic               md_done,
    output logic [1:0]         md_state
);

    localparam int SHW = $clog2(DPWIDTH);
    localparam int RW  = $clog2(RFSIZE);

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Architectural and pipeline registers
    logic [DPWIDTH-1:0] pc_q, pcc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
    logic [DPWIDTH-1:0] rf_q [RFSIZE];

    // MD unit state
    logic [1:0]         md_state_q, md_state_d;
    logic [1:0]         md_op_q, md_op_d;
    logic [DPWIDTH-1:0] md_b_q, md_b_d;
    logic [DPWIDTH-1:0] md_hi_q, md_hi_d;
    logic [DPWIDTH-1:0] md_lo_q, md_lo_d;
    logic [DPWIDTH-1:0] md_res_q, md_res_d;
    logic [CNTW-1:0]    md_cnt_q, md_cnt_d;

    // Combinational nets
    logic [31:0]        ir32;
    logic [31:0]        imm32;
    logic [DPWIDTH-1:0] imm, alu_a, alu_b, alu_result, datad, rf_a, rf_b;
    logic [SHW-1:0]     shamt;
    logic [4:0]         rs1, rs2, rd;
    logic [DPWIDTH:0]   mul_sum, div_shift;
    logic [DPWIDTH+1:0] div_trial;
    logic               div_ok;
    logic [DPWIDTH-1:0] hi_step, lo_step;

    // Narrow datapaths see the instruction word repeated to fill 32 bits,
    // so every RV32 field stays addressable; wide ones use the low 32 bits.
    generate
        if (DPWIDTH >= 32) begin : g_ir_wide
            assign ir32 = ir_q[31:0];
            if (DPWIDTH > 32) begin : g_ir_hi
                logic unused_ir_hi;
                assign unused_ir_hi = ^ir_q[DPWIDTH-1:32];
            end
            if (DPWIDTH > 32) begin : g_imm_ext
                assign imm = {{(DPWIDTH-32){imm32[31]}}, imm32};
            end else begin : g_imm_eq
                assign imm = imm32;
            end
        end else begin : g_ir_narrow
            localparam int REP = (32 + DPWIDTH - 1) / DPWIDTH;
            logic [REP*DPWIDTH-1:0] ir_rep;
            logic                   unused_narrow;
            assign ir_rep        = {REP{ir_q}};
            assign ir32          = ir_rep[31:0];
            assign imm           = imm32[DPWIDTH-1:0];
            assign unused_narrow = ^{ir_rep, imm32};
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{ir32[6:0], div_trial[DPWIDTH]};

    assign rs1 = ir32[19:15];
    assign rs2 = ir32[24:20];
    assign rd  = ir32[11:7];

    assign rf_a = (rs1 == 5'd0) ? '0 : rf_q[rs1[RW-1:0]];
    assign rf_b = (rs2 == 5'd0) ? '0 : rf_q[rs2[RW-1:0]];

    assign imem_addr    = pc_q;
    assign dmem_addr    = aluout_q;
    assign dmem_dataout = b_q;
    assign instr        = ir_q;
    assign md_busy      = (md_state_q == MD_RUN);
    assign md_done      = (md_state_q == MD_DONE);
    assign md_state     = md_state_q;

    // Immediate generation from the current instruction register
    always_comb begin
        imm32 = '0;
        case (immsel)
            3'd0: imm32 = {{12{ir32[31]}}, ir32[19:12], ir32[20], ir32[30:21], 1'b0};
            3'd1: imm32 = {{20{ir32[31]}}, ir32[7], ir32[30:25], ir32[11:8], 1'b0};
            3'd2: imm32 = {{21{ir32[31]}}, ir32[30:25], ir32[11:7]};
            3'd3: imm32 = {{21{ir32[31]}}, ir32[30:20]};
            3'd4: imm32 = {ir32[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign alu_a = asel ? pcc_q : a_q;
    assign alu_b = bsel ? imm : b_q;
    assign shamt = alu_b[SHW-1:0];
    assign zero  = (alu_result == '0);

    // ALU; unknown operation codes fall back to ADD
    always_comb begin
        alu_result = alu_a + alu_b;
        case (alusel)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLL:  alu_result = alu_a << shamt;
            ALU_SLT:  alu_result = {{(DPWIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {{(DPWIDTH-1){1'b0}}, alu_a < alu_b};
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SRL:  alu_result = alu_a >> shamt;
            ALU_SRA:  alu_result = $signed(alu_a) >>> shamt;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            default:  alu_result = alu_a + alu_b;
        endcase
    end

    // Writeback source selection
    always_comb begin
        datad = mdr_q;
        case (wbsel)
            2'd0: datad = mdr_q;
            2'd1: datad = aluout_q;
            2'd2: datad = pc_q;
            2'd3: datad = md_res_q;
            default: datad = mdr_q;
        endcase
    end

    // One radix-2 step. Multiply: {hi,lo} shifts right, adding the
    // multiplicand into hi when lo[0] is set. Divide: {hi,lo} shifts left,
    // hi is the partial remainder and quotient bits enter lo from the right.
    // A zero divisor never borrows, which yields all-ones / dividend.
    always_comb begin
        mul_sum   = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_b_q} : '0);
        div_shift = {md_hi_q, md_lo_q[DPWIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, md_b_q};
        div_ok    = ~div_trial[DPWIDTH+1];
        if (md_op_q[1]) begin
            hi_step = div_ok ? div_trial[DPWIDTH-1:0] : div_shift[DPWIDTH-1:0];
            lo_step = {md_lo_q[DPWIDTH-2:0], div_ok};
        end else begin
            hi_step = mul_sum[DPWIDTH:1];
            lo_step = {mul_sum[0], md_lo_q[DPWIDTH-1:1]};
        end
    end

    // MD FSM next-state; operands are captured when a start is accepted
    always_comb begin
        md_state_d = md_state_q;
        md_op_d    = md_op_q;
        md_b_d     = md_b_q;
        md_hi_d    = md_hi_q;
        md_lo_d    = md_lo_q;
        md_cnt_d   = md_cnt_q;
        md_res_d   = md_res_q;
        case (md_state_q)
            MD_IDLE, MD_DONE: begin
                md_state_d = MD_IDLE;
                if (md_start) begin
                    md_state_d = MD_RUN;
                    md_op_d    = md_op;
                    md_b_d     = b_q;
                    md_lo_d    = a_q;
                    md_hi_d    = '0;
                    md_cnt_d   = '0;
                end
            end
            MD_RUN: begin
                md_hi_d  = hi_step;
                md_lo_d  = lo_step;
                md_cnt_d = md_cnt_q + CNTW'(1);
                if (md_cnt_q == CNTW'(DPWIDTH - 1)) begin
                    md_state_d = MD_DONE;
                    // MULHU and REMU take the high half, MUL and DIVU the low
                    md_res_d   = md_op_q[0] ? hi_step : lo_step;
                end
            end
            default: md_state_d = MD_IDLE;
        endcase
    end

    // MD unit registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_state_q <= MD_IDLE;
            md_op_q    <= '0;
            md_b_q     <= '0;
            md_hi_q    <= '0;
            md_lo_q    <= '0;
            md_cnt_q   <= '0;
            md_res_q   <= '0;
        end else begin
            md_state_q <= md_state_d;
            md_op_q    <= md_op_d;
            md_b_q     <= md_b_d;
            md_hi_q    <= md_hi_d;
            md_lo_q    <= md_lo_d;
            md_cnt_q   <= md_cnt_d;
            md_res_q   <= md_res_d;
        end
    end

    // Datapath registers: enabled loads plus free-running a/b/aluout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            pcc_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (pcwrite)  pc_q  <= pcsource ? aluout_q : pc_q + DPWIDTH'(4);
            if (pccen)    pcc_q <= pc_q;
            if (irwrite)  ir_q  <= imem_datain;
            if (mdrwrite) mdr_q <= dmem_datain;
            a_q      <= rf_a;
            b_q      <= rf_b;
            aluout_q <= alu_result;
        end
    end

    // Register file write port (not reset; x0 never written)
    always_ff @(posedge clk) begin
        if (regwen && (rd != 5'd0)) rf_q[rd[RW-1:0]] <= datad;
    end

endmodule

// File: tb/tb_rv_dp_md.sv
// Directed bench for rv_dp_md: a 32-bit instance for the datapath and all
// MD operations, and a 16-bit instance for a narrow-width multiply.
module tb_rv_dp_md;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // 32-bit instance signals
    logic [31:0] imem_addr, imem_datain, dmem_addr, dmem_dataout, dmem_datain, instr;
    logic        zero, pcsource, pcwrite, pccen, irwrite, mdrwrite, regwen;
    logic [1:0]  wbsel, md_op, md_state;
    logic [2:0]  immsel;
    logic        asel, bsel, md_start, md_busy, md_done;
    logic [3:0]  alusel;

    // 16-bit instance signals
    logic [15:0] imem_addr_s, imem_datain_s, dmem_addr_s, dmem_dataout_s, dmem_datain_s, instr_s;
    logic        zero_s, irwrite_s, mdrwrite_s, regwen_s, md_start_s, md_busy_s, md_done_s;
    logic [1:0]  wbsel_s, md_op_s, md_state_s;

    rv_dp_md #(.DPWIDTH(32), .RFSIZE(32)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_datain(imem_datain),
        .dmem_addr(dmem_addr), .dmem_dataout(dmem_dataout), .dmem_datain(dmem_datain),
        .instr(instr), .zero(zero),
        .pcsource(pcsource), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .mdrwrite(mdrwrite), .regwen(regwen), .wbsel(wbsel), .immsel(immsel),
        .asel(asel), .bsel(bsel), .alusel(alusel),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
        .md_state(md_state)
    );

    rv_dp_md #(.DPWIDTH(16), .RFSIZE(32)) dut16 (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr_s), .imem_datain(imem_datain_s),
        .dmem_addr(dmem_addr_s), .dmem_dataout(dmem_dataout_s), .dmem_datain(dmem_datain_s),
        .instr(instr_s), .zero(zero_s),
        .pcsource(1'b0), .pcwrite(1'b0), .pccen(1'b0), .irwrite(irwrite_s),
        .mdrwrite(mdrwrite_s), .regwen(regwen_s), .wbsel(wbsel_s), .immsel(3'd0),
        .asel(1'b0), .bsel(1'b0), .alusel(4'd0),
        .md_start(md_start_s), .md_op(md_op_s), .md_busy(md_busy_s), .md_done(md_done_s),
        .md_state(md_state_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic set_ir(input logic [31:0] v);
        imem_datain = v;
        irwrite = 1'b1;
        tick();
        irwrite = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        imem_datain = rtype(rd, 5'd0, 5'd0);
        irwrite = 1'b1;
        dmem_datain = val;
        mdrwrite = 1'b1;
        tick();
        irwrite = 1'b0;
        mdrwrite = 1'b0;
        wbsel = 2'd0;
        regwen = 1'b1;
        tick();
        regwen = 1'b0;
    endtask

    // Load ir with the source fields, then one edge to load a/b
    task automatic select_ops(input logic [4:0] rs1, input logic [4:0] rs2);
        set_ir(rtype(5'd0, rs1, rs2));
        tick();
    endtask

    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (md_done !== 1'b1 && n < 200) begin
            if (md_busy === 1'b1) busy_n++;
            tick();
            n++;
        end
    endtask

    // Full operation: start, latency/busy checks, pulse width check
    task automatic run_md(input logic [1:0] op, input string tag);
        int n, bn;
        md_op = op;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        wait_done(n, bn);
        chk({tag, "_latency"}, n, 32);
        chk({tag, "_busy_cycles"}, bn, 32);
        chk({tag, "_busy_at_done"}, md_busy, 1'b0);
        tick();
        chk({tag, "_done_pulse"}, md_done, 1'b0);
    endtask

    // Write md result to x5 through wbsel=3, then read x5 back on b
    task automatic read_md(input logic [31:0] exp, input string tag);
        set_ir(rtype(5'd5, 5'd0, 5'd5));
        wbsel = 2'd3;
        regwen = 1'b1;
        tick();
        regwen = 1'b0;
        tick();
        chk(tag, dmem_dataout, exp);
    endtask

    initial begin
        int n, bn, dones;
        imem_datain = '0; dmem_datain = '0;
        pcsource = 0; pcwrite = 0; pccen = 0; irwrite = 0; mdrwrite = 0; regwen = 0;
        wbsel = 0; immsel = 0; asel = 0; bsel = 0; alusel = 0; md_start = 0; md_op = 0;
        imem_datain_s = '0; dmem_datain_s = '0;
        irwrite_s = 0; mdrwrite_s = 0; regwen_s = 0; wbsel_s = 0; md_start_s = 0; md_op_s = 0;

        // Reset state
        tick(); tick();
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_ir", instr, 32'h0);
        chk("rst_aluout", dmem_addr, 32'h0);
        chk("rst_b", dmem_dataout, 32'h0);
        chk("rst_busy", md_busy, 1'b0);
        chk("rst_done", md_done, 1'b0);
        chk("rst_state", md_state, 2'd0);
        rst = 1'b1;
        tick();

        // U-type immediate through the ALU with pcc (0) as operand A
        set_ir(32'hABCDE0B7);
        asel = 1; bsel = 1; immsel = 3'd4; alusel = 4'd0;
        tick();
        chk("imm_u", dmem_addr, 32'hABCDE000);
        chk("zero_low", zero, 1'b0);

        // pc from aluout, then sequential increment
        pcwrite = 1; pcsource = 1;
        tick();
        chk("pc_jump", imem_addr, 32'hABCDE000);
        pcsource = 0;
        tick();
        chk("pc_plus4", imem_addr, 32'hABCDE004);
        pcwrite = 0;

        // I-type sign extension, then pc wraparound past 2^32
        set_ir(32'hFFF00093);
        immsel = 3'd3;
        tick();
        chk("imm_i_neg", dmem_addr, 32'hFFFFFFFF);
        pcwrite = 1; pcsource = 1;
        tick();
        chk("pc_jump_max", imem_addr, 32'hFFFFFFFF);
        pcsource = 0;
        tick();
        chk("pc_wrap", imem_addr, 32'h00000003);
        pcwrite = 0;

        // Unused immsel code gives 0: 0 + 0 drives zero high
        immsel = 3'd6;
        #1;
        chk("zero_high", zero, 1'b1);
        asel = 0; bsel = 0; immsel = 0;

        // Register file: x0 stays zero, normal write/read, ALU SUB
        write_reg(5'd0, 32'h55);
        write_reg(5'd3, 32'h12345678);
        select_ops(5'd0, 5'd0);
        chk("x0_reads_zero", dmem_dataout, 32'h0);
        select_ops(5'd0, 5'd3);
        chk("rf_x3", dmem_dataout, 32'h12345678);
        write_reg(5'd1, 32'd7);
        write_reg(5'd2, 32'd6);
        select_ops(5'd1, 5'd2);
        alusel = 4'd1;
        tick();
        chk("alu_sub", dmem_addr, 32'd1);
        alusel = 4'd3;
        tick();
        chk("alu_slt", dmem_addr, 32'd0);
        alusel = 4'd0;

        // MUL 7*6
        run_md(2'd0, "mul_7x6");
        read_md(32'd42, "mul_7x6_res");

        // MULHU / MUL on all-ones
        write_reg(5'd1, 32'hFFFFFFFF);
        write_reg(5'd2, 32'hFFFFFFFF);
        select_ops(5'd1, 5'd2);
        run_md(2'd1, "mulhu_max");
        read_md(32'hFFFFFFFE, "mulhu_max_res");
        select_ops(5'd1, 5'd2);
        run_md(2'd0, "mul_max");
        read_md(32'h00000001, "mul_max_res");

        // DIVU / REMU 100/7
        write_reg(5'd1, 32'd100);
        write_reg(5'd2, 32'd7);
        select_ops(5'd1, 5'd2);
        run_md(2'd2, "divu_100_7");
        read_md(32'd14, "divu_100_7_res");
        select_ops(5'd1, 5'd2);
        run_md(2'd3, "remu_100_7");
        read_md(32'd2, "remu_100_7_res");

        // Divide by zero
        write_reg(5'd1, 32'h1234);
        write_reg(5'd2, 32'd0);
        select_ops(5'd1, 5'd2);
        run_md(2'd2, "divu_by0");
        read_md(32'hFFFFFFFF, "divu_by0_res");
        select_ops(5'd1, 5'd2);
        run_md(2'd3, "remu_by0");
        read_md(32'h1234, "remu_by0_res");

        // md_start during RUN is ignored
        write_reg(5'd1, 32'd3);
        write_reg(5'd2, 32'd5);
        write_reg(5'd3, 32'd100);
        write_reg(5'd4, 32'd7);
        select_ops(5'd1, 5'd2);
        md_op = 2'd0;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (5) tick();
        chk("ign_state_run", md_state, 2'd1);
        md_op = 2'd2;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        md_op = 2'd0;
        wait_done(n, bn);
        chk("ign_latency", n, 26);
        tick();
        read_md(32'd15, "ign_res");

        // Back-to-back: start held in the DONE cycle with new operands
        select_ops(5'd1, 5'd2);
        md_op = 2'd0;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        select_ops(5'd3, 5'd4);
        wait_done(n, bn);
        chk("b2b_first_latency", n, 30);
        md_op = 2'd2;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        chk("b2b_restart_busy", md_busy, 1'b1);
        read_md(32'd15, "b2b_first_res_held");
        wait_done(n, bn);
        chk("b2b_done_spacing", n + 4, 33);
        tick();
        read_md(32'd14, "b2b_second_res");

        // Reset mid-run aborts the operation
        select_ops(5'd1, 5'd2);
        md_op = 2'd0;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (3) tick();
        chk("abort_busy_before", md_busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_pc", imem_addr, 32'h0);
        chk("abort_ir", instr, 32'h0);
        chk("abort_aluout", dmem_addr, 32'h0);
        chk("abort_b", dmem_dataout, 32'h0);
        chk("abort_busy", md_busy, 1'b0);
        chk("abort_done", md_done, 1'b0);
        #2 rst = 1'b1;
        dones = 0;
        repeat (40) begin
            tick();
            if (md_done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_pc_after", imem_addr, 32'h0);

        // 16-bit instance: 255*255 in 16 iterations
        imem_datain_s = 16'h0080;
        irwrite_s = 1; dmem_datain_s = 16'd255; mdrwrite_s = 1;
        tick();
        irwrite_s = 0; mdrwrite_s = 0; wbsel_s = 0; regwen_s = 1;
        tick();
        regwen_s = 0;
        imem_datain_s = 16'h0100;
        irwrite_s = 1; mdrwrite_s = 1;
        tick();
        irwrite_s = 0; mdrwrite_s = 0; regwen_s = 1;
        tick();
        regwen_s = 0;
        imem_datain_s = 16'h8020;
        irwrite_s = 1;
        tick();
        irwrite_s = 0;
        tick();
        md_op_s = 2'd0;
        md_start_s = 1'b1;
        tick();
        md_start_s = 1'b0;
        n = 0;
        while (md_done_s !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("w16_latency", n, 16);
        imem_datain_s = 16'h0280;
        irwrite_s = 1;
        tick();
        irwrite_s = 0; wbsel_s = 2'd3; regwen_s = 1;
        tick();
        regwen_s = 0;
        imem_datain_s = 16'h0050;
        irwrite_s = 1;
        tick();
        irwrite_s = 0;
        tick();
        chk("w16_mul_res", dmem_dataout_s, 16'hFE01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
